generic_fifo_sc_c: RTL and testbench

//   Single-clock FIFO, next generation of the sc FIFO family: internal register-array storage,

---
 rtl/generic_fifo_sc_c.sv | 155 +++++++++++++++
 tb/tb_generic_fifo_sc_c.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/generic_fifo_sc_c.sv
// generic_fifo_sc_c: single-clock FIFO built on an internal register array.
// It keeps an exact occupancy count and registered empty/full flags, with
// almost-empty and almost-full thresholds that can be changed at run time.
// The overflow and underflow error flags are sticky, and every push and pop
// is guarded by the registered flags.
// Optional build macro: SC_FIFO_FWFT_EN selects first-word-fall-through mode,
// where dout shows the head word combinationally. With the macro undefined,
// dout is registered and has a 1-cycle read latency.
module generic_fifo_sc_c #(
  parameter int unsigned dw = 8,
  parameter int unsigned aw = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [dw-1:0] din,
  input  logic          we,
  input  logic          re,
  input  logic [aw:0]   ae_thr,
  input  logic [aw:0]   af_thr,
  output logic [dw-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          aempty,
  output logic          afull,
  output logic [aw:0]   cnt,
  output logic          ovf,
  output logic          udf
);

  localparam int unsigned DEPTH = 1 << aw;
  localparam int unsigned CW    = aw + 1;

  logic [dw-1:0] mem_q [DEPTH];

  logic [aw:0]   wp_q, wp_d;
  logic [aw:0]   rp_q, rp_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          aempty_q, aempty_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push_c, pop_c;
  logic [aw:0]   cnt_nx;
`ifndef SC_FIFO_FWFT_EN
  logic [dw-1:0] dout_q, dout_d;
`endif

  // Guarded push/pop from registered flags; clear suppresses both
  assign push_c = we & ~full_q  & ~clr;
  assign pop_c  = re & ~empty_q & ~clr;
  assign cnt_nx = cnt_q + CW'(push_c) - CW'(pop_c);

  // Next-state for pointers, count, flags and error bits
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    empty_d  = empty_q;
    full_d   = full_q;
    aempty_d = aempty_q;
    afull_d  = afull_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
`ifndef SC_FIFO_FWFT_EN
    dout_d   = dout_q;
`endif
    if (clr) begin
      wp_d     = '0;
      rp_d     = '0;
      cnt_d    = '0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      aempty_d = 1'b1;
      afull_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      wp_d     = wp_q + CW'(push_c);
      rp_d     = rp_q + CW'(pop_c);
      cnt_d    = cnt_nx;
      empty_d  = (cnt_nx == '0);
      full_d   = (cnt_nx == CW'(DEPTH));
      aempty_d = (cnt_nx <= ae_thr);
      afull_d  = (cnt_nx >= af_thr);
      ovf_d    = ovf_q | (we & full_q);
      udf_d    = udf_q | (re & empty_q);
`ifndef SC_FIFO_FWFT_EN
      if (pop_c) dout_d = mem_q[rp_q[aw-1:0]];
`endif
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
`ifndef SC_FIFO_FWFT_EN
      dout_q   <= '0;
`endif
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
`ifndef SC_FIFO_FWFT_EN
      dout_q   <= dout_d;
`endif
    end
  end

  // Storage array; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wp_q[aw-1:0]] <= din;
  end

`ifndef SYNTHESIS
  // Simulation-only warnings on error events
  always_ff @(posedge clk) begin
    if (!rst && !clr && we && full_q)
      $display("WARNING: generic_fifo_sc_c overflow at %0t", $time);
    if (!rst && !clr && re && empty_q)
      $display("WARNING: generic_fifo_sc_c underflow at %0t", $time);
  end
`endif

`ifdef SC_FIFO_FWFT_EN
  assign dout   = mem_q[rp_q[aw-1:0]];
`else
  assign dout   = dout_q;
`endif
  assign empty  = empty_q;
  assign full   = full_q;
  assign aempty = aempty_q;
  assign afull  = afull_q;
  assign cnt    = cnt_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_generic_fifo_sc_c.sv
// Directed bench for generic_fifo_sc_c (aw=2, dw=8) with a read-data scoreboard.
module tb_generic_fifo_sc_c;

  logic       clk = 1'b0;
  logic       rst, clr, we, re;
  logic [7:0] din;
  logic [2:0] ae_thr, af_thr;
  logic [7:0] dout;
  logic       empty, full, aempty, afull, ovf, udf;
  logic [2:0] cnt;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  logic       exp_rd = 1'b0;
  logic       rd_pend = 1'b0;

  generic_fifo_sc_c #(.dw(8), .aw(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
    .ae_thr(ae_thr), .af_thr(af_thr), .dout(dout), .empty(empty),
    .full(full), .aempty(aempty), .afull(afull), .cnt(cnt),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compares read data whenever a successful pop is expected
`ifdef SC_FIFO_FWFT_EN
  always @(negedge clk) begin
    if (exp_rd) begin
      logic [7:0] e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_data: read with empty scoreboard, got %h", dout);
      end else begin
        e = sb.pop_front();
        if (dout !== e) begin
          bad++;
          $display("FAIL rd_data: got %h expected %h", dout, e);
        end
      end
    end
  end
`else
  always @(posedge clk) rd_pend <= exp_rd;
  always @(negedge clk) begin
    if (rd_pend) begin
      logic [7:0] e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_data: read with empty scoreboard, got %h", dout);
      end else begin
        e = sb.pop_front();
        if (dout !== e) begin
          bad++;
          $display("FAIL rd_data: got %h expected %h", dout, e);
        end
      end
    end
  end
`endif

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flag order: empty full aempty afull ovf udf
  task automatic chk(input string name, input logic [2:0] c, input logic [5:0] f);
    chk_val(name, 32'({cnt, empty, full, aempty, afull, ovf, udf}), 32'({c, f}));
  endtask

  task automatic step(input logic w, input logic r, input logic c,
                      input logic [7:0] d, input logic er, input logic [7:0] ed);
    we = w; re = r; clr = c; din = d; exp_rd = er;
    if (er) sb.push_back(ed);
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr = 1'b0; exp_rd = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, 1'b0, 1'b0, d, 1'b0, 8'h00);
  endtask

  task automatic pop(input logic [7:0] ed);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, ed);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
    ae_thr = 3'd0; af_thr = 3'd4;
    #12;
    chk("reset_state", 3'd0, 6'b101000);
`ifndef SC_FIFO_FWFT_EN
    chk_val("reset_dout", 32'(dout), 32'h00);
`endif
    rst = 1'b0;

    // 1: fill and drain
    push(8'hA1); chk("t1_push1", 3'd1, 6'b000000);
    push(8'hA2); chk("t1_push2", 3'd2, 6'b000000);
    push(8'hA3); chk("t1_push3", 3'd3, 6'b000000);
    push(8'hA4); chk("t1_push4", 3'd4, 6'b010100);
    pop(8'hA1);  chk("t1_pop1", 3'd3, 6'b000000);
    pop(8'hA2);  chk("t1_pop2", 3'd2, 6'b000000);
    pop(8'hA3);  chk("t1_pop3", 3'd1, 6'b000000);
    pop(8'hA4);  chk("t1_pop4", 3'd0, 6'b101000);

    // 2: overflow, underflow, clear of sticky flags
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    chk("t2_full", 3'd4, 6'b010100);
    push(8'hFF); chk("t2_ovf", 3'd4, 6'b010110);
    pop(8'hB1);  chk("t2_pop1", 3'd3, 6'b000010);
    pop(8'hB2); pop(8'hB3); pop(8'hB4);
    chk("t2_drained", 3'd0, 6'b101010);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("t2_udf", 3'd0, 6'b101011);
`ifndef SC_FIFO_FWFT_EN
    chk_val("t2_dout_hold", 32'(dout), 32'hB4);
`endif
    push(8'hC1); chk("t2_push_after_udf", 3'd1, 6'b000011);
    pop(8'hC1);  chk("t2_pop_after_udf", 3'd0, 6'b101011);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    chk("t2_clr", 3'd0, 6'b101000);

    // 3: steady-state push+pop across pointer wrap
    push(8'h0E); push(8'h0F);
    chk("t3_cnt2", 3'd2, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 8'h0E); chk("t3_wr0", 3'd2, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'h0F); chk("t3_wr1", 3'd2, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 8'h10); chk("t3_wr2", 3'd2, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 8'h13, 1'b1, 8'h11); chk("t3_wr3", 3'd2, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 8'h14, 1'b1, 8'h12); chk("t3_wr4", 3'd2, 6'b000000);
    step(1'b1, 1'b1, 1'b0, 8'h15, 1'b1, 8'h13); chk("t3_wr5", 3'd2, 6'b000000);
    pop(8'h14); pop(8'h15);
    chk("t3_drained", 3'd0, 6'b101000);

    // 4: programmable thresholds
    ae_thr = 3'd1; af_thr = 3'd3;
    push(8'h40); chk("t4_c1", 3'd1, 6'b001000);
    push(8'h41); chk("t4_c2", 3'd2, 6'b000000);
    push(8'h42); chk("t4_c3", 3'd3, 6'b000100);
    af_thr = 3'd4;
    idle();      chk("t4_afthr4", 3'd3, 6'b000000);
    push(8'h43); chk("t4_c4", 3'd4, 6'b010100);
    pop(8'h40);  chk("t4_p3", 3'd3, 6'b000000);
    pop(8'h41);  chk("t4_p2", 3'd2, 6'b000000);
    pop(8'h42);  chk("t4_p1", 3'd1, 6'b001000);
    pop(8'h43);  chk("t4_p0", 3'd0, 6'b101000);
    ae_thr = 3'd4; af_thr = 3'd0;
    idle();      chk("t4_thr_extremes", 3'd0, 6'b101100);
    ae_thr = 3'd0; af_thr = 3'd4;
    idle();      chk("t4_thr_restore", 3'd0, 6'b101000);

    // 5: clear dominates simultaneous push/pop
    push(8'h50); push(8'h51); push(8'h52); push(8'h53);
    push(8'hFF); pop(8'h50);
    chk("t5_pre_clr", 3'd3, 6'b000010);
    step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, 8'h00);
    chk("t5_clr", 3'd0, 6'b101000);
`ifndef SC_FIFO_FWFT_EN
    chk_val("t5_dout_hold", 32'(dout), 32'h50);
`endif
    push(8'h5C); chk("t5_push", 3'd1, 6'b000000);
    pop(8'h5C);  chk("t5_pop", 3'd0, 6'b101000);

    // 6: asynchronous reset mid-burst
    push(8'h60); push(8'h61);
    chk("t6_cnt2", 3'd2, 6'b000000);
    we = 1'b1; din = 8'h62;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", 3'd0, 6'b101000);
`ifndef SC_FIFO_FWFT_EN
    chk_val("t6_rst_dout", 32'(dout), 32'h00);
`endif
    we = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    push(8'h5A); chk("t6_push", 3'd1, 6'b000000);
    pop(8'h5A);  chk("t6_pop", 3'd0, 6'b101000);

    idle(); idle();
    chk_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
